// File: rtl/bf16_pkg.sv
// Shared bf16 constants, in-flight chunk tag and sequencer state type
// for the dot-product sequencer.
package bf16_pkg;

  localparam logic [15:0] BF16_PINF  = 16'h7F80;
  localparam logic [15:0] BF16_NINF  = 16'hFF80;
  localparam logic [15:0] BF16_QNAN  = 16'h7FC1;
  localparam logic [15:0] BF16_PZERO = 16'h0000;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } bf16_tag_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} bf16_state_e;

endpackage

// File: rtl/bf16_add.sv
// Combinational two-operand bf16 adder: round-to-nearest-even, subnormals
// flushed to signed zero, canonical NaN 7FC1 matching the MAC tree.
module bf16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  import bf16_pkg::*;

  logic              sl, ss;
  logic [7:0]        el, es, d;
  logic [6:0]        ml, ms;
  logic [3:0]        dcap, lz;
  logic [10:0]       mx_l, mx_s, norm;
  logic [21:0]       ext;
  logic [11:0]       sum;
  logic [8:0]        mant;
  logic [6:0]        mant_field;
  logic signed [9:0] exp_r;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rnd, found;

  // Operands are swapped so the larger magnitude is always the minuend; the
  // smaller one is aligned with guard/round/sticky bits before the add.
  always_comb begin
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    if (a[14:0] >= b[14:0]) begin
      sl = a[15]; el = a[14:7]; ml = a[6:0];
      ss = b[15]; es = b[14:7]; ms = b[6:0];
    end else begin
      sl = b[15]; el = b[14:7]; ml = b[6:0];
      ss = a[15]; es = a[14:7]; ms = a[6:0];
    end
    d     = el - es;
    dcap  = (d > 8'd15) ? 4'd15 : d[3:0];
    mx_l  = {1'b1, ml, 3'b000};
    mx_s  = {1'b1, ms, 3'b000};
    ext   = {mx_s, 11'd0} >> dcap;
    exp_r = $signed({2'b00, el});
    if (sl == ss) begin
      sum = {1'b0, mx_l} + {1'b0, ext[21:11] | {10'd0, |ext[10:0]}};
      if (sum[11]) begin
        norm  = {sum[11:2], sum[1] | sum[0]};
        exp_r = exp_r + 10'sd1;
      end else begin
        norm = sum[10:0];
      end
    end else begin
      sum  = {1'b0, mx_l} - {1'b0, ext[21:11] | {10'd0, |ext[10:0]}};
      norm = sum[10:0];
    end
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && norm[i]) begin
        lz    = 4'(10 - i);
        found = 1'b1;
      end
    end
    norm       = norm << lz;
    exp_r      = exp_r - $signed({6'd0, lz});
    rnd        = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant       = {1'b0, norm[10:3]} + {8'd0, rnd};
    mant_field = mant[8] ? mant[7:1] : mant[6:0];
    if (mant[8]) exp_r = exp_r + 10'sd1;

    if (a_nan || b_nan)             y = BF16_QNAN;
    else if (a_inf && b_inf)        y = (a[15] == b[15]) ? a : BF16_QNAN;
    else if (a_inf)                 y = a;
    else if (b_inf)                 y = b;
    else if (a_zero && b_zero)      y = {a[15] & b[15], 15'd0};
    else if (a_zero)                y = b;
    else if (b_zero)                y = a;
    else if (norm == 11'd0)         y = BF16_PZERO;
    else if (exp_r >= 10'sd255)     y = {sl, BF16_PINF[14:0]};
    else if (exp_r <= 10'sd0)       y = {sl, 15'd0};
    else                            y = {sl, exp_r[7:0], mant_field};
  end

endmodule

// File: rtl/bf16_dot_seq.sv
// Streams 8-pair operand chunks into an external bf16 MAC tree and folds the
// tree outputs into a single bf16 dot-product result with a valid/ready port.
module bf16_dot_seq #(
  parameter int TREE_LAT   = 2,
  parameter int MAX_CHUNKS = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [255:0]     chk_data,
  input  logic             chk_last,
  output logic [255:0]     tree_in,
  input  logic [15:0]      tree_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] res_cnt,
  output logic             ovf
);
  import bf16_pkg::*;

  bf16_state_e      state, next_state;
  bf16_tag_t        tags [TREE_LAT];
  bf16_tag_t        exit_tag;
  logic [CNT_W-1:0] count;
  logic [15:0]      acc, add_sum, acc_next;
  logic             commit, accept, handshake;

  assign chk_ready = !reset && ((state == IDLE) || (state == RUN));
  assign accept    = chk_valid && chk_ready;
  assign res_valid = (state == HOLD);
  assign handshake = res_valid && res_ready;
  assign exit_tag  = tags[TREE_LAT-1];
  assign acc_next  = exit_tag.first ? tree_out : add_sum;

  bf16_add u_add (.a(acc), .b(tree_out), .y(add_sum));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = chk_last ? DRAIN : RUN;
      RUN:     if (accept && chk_last) next_state = DRAIN;
      DRAIN:   if (commit) next_state = HOLD;
      HOLD:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // commit marks that the last chunk has been folded into res_data; DRAIN
  // waits on it, which puts res_valid one cycle after the final retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tree_in  <= '0;
      count    <= '0;
      acc      <= '0;
      res_data <= '0;
      res_cnt  <= '0;
      ovf      <= 1'b0;
      commit   <= 1'b0;
      for (int i = 0; i < TREE_LAT; i++) tags[i] <= '0;
    end else begin
      state   <= next_state;
      tree_in <= accept ? chk_data : '0;
      tags[0] <= '{v: accept, first: accept && (count == '0), last: accept && chk_last};
      for (int i = 1; i < TREE_LAT; i++) tags[i] <= tags[i-1];
      if (handshake) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (accept) begin
        if (count == CNT_W'(MAX_CHUNKS)) ovf <= 1'b1;
        else count <= count + 1'b1;
      end
      if (state == DRAIN && commit) commit <= 1'b0;
      if (exit_tag.v) begin
        acc <= acc_next;
        if (exit_tag.last) begin
          res_data <= acc_next;
          res_cnt  <= count;
          commit   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bf16_dot_seq.sv
// Directed bench for bf16_dot_seq with a two-cycle behavioural stand-in for
// the MAC tree that recognises the chunks used below.
module tb_bf16_dot_seq;

  localparam logic [255:0] CHK_A = {192'd0, 16'h4080, 16'h4040, 16'h4000, 16'h3F80};
  localparam logic [255:0] CHK_B = {224'd0, 16'h4000, 16'h4000};
  localparam logic [255:0] CHK_C = {224'd0, 16'h3F80, 16'h7F80};
  localparam logic [255:0] CHK_D = {224'd0, 16'h3F80, 16'hFF80};
  localparam logic [255:0] CHK_E = {224'd0, 16'h4000, 16'hBF80};
  localparam logic [255:0] CHK_F = {224'd0, 16'h3F80, 16'h3F80};

  logic         clk = 1'b0;
  logic         reset, chk_valid, chk_ready, chk_last, res_valid, res_ready, ovf;
  logic [255:0] chk_data, tree_in;
  logic [15:0]  tree_out, res_data;
  logic [15:0]  tree_q = '0;
  logic [6:0]   res_cnt;
  int           checks = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  bf16_dot_seq dut (
    .clk(clk), .reset(reset), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .chk_data(chk_data), .chk_last(chk_last), .tree_in(tree_in), .tree_out(tree_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cnt(res_cnt), .ovf(ovf)
  );

  // Hand-computed sum of the eight pair products for each known chunk.
  function automatic logic [15:0] tree_model(input logic [255:0] d);
    if (d == CHK_A) return 16'h4160;
    if (d == CHK_B) return 16'h4080;
    if (d == CHK_C) return 16'h7F80;
    if (d == CHK_D) return 16'hFF80;
    if (d == CHK_E) return 16'hC000;
    if (d == CHK_F) return 16'h3F80;
    return 16'h0000;
  endfunction

  always @(posedge clk) tree_q <= tree_model(tree_in);
  assign tree_out = tree_q;

  task automatic send_chunk(input logic [255:0] d, input logic last);
    chk_valid = 1'b1; chk_data = d; chk_last = last;
    @(posedge clk); #1;
    chk_valid = 1'b0; chk_data = '0; chk_last = 1'b0;
  endtask

  task automatic wait_result(output int cycles, output logic ready_seen);
    cycles = -1;
    ready_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (chk_ready) ready_seen = 1'b1;
      if (res_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; chk_valid = 1'b0; chk_data = '0; chk_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (chk_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset.chk_ready: got %b expected 0", chk_ready); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset.res_valid: got %b expected 0", res_valid); end
    checks++; if (tree_in !== 256'd0) begin fails++; $display("[TB] FAIL reset.tree_in: got %h expected 0", tree_in); end
    checks++; if (res_data !== 16'h0000) begin fails++; $display("[TB] FAIL reset.res_data: got %h expected 0000", res_data); end
    checks++; if (res_cnt !== 7'd0) begin fails++; $display("[TB] FAIL reset.res_cnt: got %0d expected 0", res_cnt); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset.ovf: got %b expected 0", ovf); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (chk_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset.ready_after: got %b expected 1", chk_ready); end
  endtask

  task automatic test_one_chunk();
    int cyc; logic rs;
    send_chunk(CHK_A, 1'b1);
    checks++; if (tree_in !== CHK_A) begin fails++; $display("[TB] FAIL one.tree_in: got %h expected %h", tree_in, CHK_A); end
    wait_result(cyc, rs);
    checks++; if (cyc !== 3) begin fails++; $display("[TB] FAIL one.latency: got %0d expected 3", cyc); end
    checks++; if (res_data !== 16'h4160) begin fails++; $display("[TB] FAIL one.res_data: got %h expected 4160", res_data); end
    checks++; if (res_cnt !== 7'd1) begin fails++; $display("[TB] FAIL one.res_cnt: got %0d expected 1", res_cnt); end
    checks++; if (rs !== 1'b0) begin fails++; $display("[TB] FAIL one.ready_in_drain: got %b expected 0", rs); end
    consume();
  endtask

  task automatic test_two_chunks();
    int cyc; logic rs;
    send_chunk(CHK_A, 1'b0);
    send_chunk(CHK_B, 1'b1);
    wait_result(cyc, rs);
    checks++; if (cyc !== 3) begin fails++; $display("[TB] FAIL two.latency: got %0d expected 3", cyc); end
    checks++; if (res_data !== 16'h4190) begin fails++; $display("[TB] FAIL two.res_data: got %h expected 4190", res_data); end
    checks++; if (res_cnt !== 7'd2) begin fails++; $display("[TB] FAIL two.res_cnt: got %0d expected 2", res_cnt); end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc; logic rs; logic unstable; logic ready_hold;
    send_chunk(CHK_A, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (chk_ready !== 1'b1) begin fails++; $display("[TB] FAIL bubble.ready_run: got %b expected 1", chk_ready); end
    send_chunk(CHK_B, 1'b1);
    wait_result(cyc, rs);
    checks++; if (res_data !== 16'h4190) begin fails++; $display("[TB] FAIL bubble.res_data: got %h expected 4190", res_data); end
    unstable = 1'b0; ready_hold = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_data !== 16'h4190 || res_cnt !== 7'd2) unstable = 1'b1;
      if (chk_ready !== 1'b0) ready_hold = 1'b1;
    end
    checks++; if (unstable !== 1'b0) begin fails++; $display("[TB] FAIL bubble.hold_stable: got data %h cnt %0d expected 4190/2", res_data, res_cnt); end
    checks++; if ((rs | ready_hold) !== 1'b0) begin fails++; $display("[TB] FAIL bubble.ready_drain_hold: got 1 expected 0"); end
    consume();
    checks++; if (chk_ready !== 1'b1) begin fails++; $display("[TB] FAIL bubble.ready_after_hs: got %b expected 1", chk_ready); end
  endtask

  task automatic test_inf_nan();
    int cyc; logic rs;
    send_chunk(CHK_C, 1'b0);
    send_chunk(CHK_D, 1'b1);
    wait_result(cyc, rs);
    checks++; if (res_data !== 16'h7FC1) begin fails++; $display("[TB] FAIL inf.nan: got %h expected 7FC1", res_data); end
    consume();
    send_chunk(CHK_C, 1'b1);
    wait_result(cyc, rs);
    checks++; if (res_data !== 16'h7F80) begin fails++; $display("[TB] FAIL inf.pinf: got %h expected 7F80", res_data); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int cyc; logic rs; logic stale;
    send_chunk(CHK_A, 1'b0);
    send_chunk(CHK_A, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stale = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin fails++; $display("[TB] FAIL midreset.stale: got 1 expected 0"); end
    send_chunk(CHK_E, 1'b1);
    wait_result(cyc, rs);
    checks++; if (cyc !== 3) begin fails++; $display("[TB] FAIL midreset.latency: got %0d expected 3", cyc); end
    checks++; if (res_data !== 16'hC000) begin fails++; $display("[TB] FAIL midreset.res_data: got %h expected C000", res_data); end
    checks++; if (res_cnt !== 7'd1) begin fails++; $display("[TB] FAIL midreset.res_cnt: got %0d expected 1", res_cnt); end
    consume();
  endtask

  task automatic test_overflow();
    int cyc; logic rs;
    for (int i = 0; i < 64; i++) send_chunk(CHK_F, 1'b0);
    checks++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL ovf.at_max: got %b expected 0", ovf); end
    send_chunk(CHK_F, 1'b1);
    checks++; if (ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf.set: got %b expected 1", ovf); end
    wait_result(cyc, rs);
    checks++; if (cyc !== 3) begin fails++; $display("[TB] FAIL ovf.latency: got %0d expected 3", cyc); end
    checks++; if (res_cnt !== 7'd64) begin fails++; $display("[TB] FAIL ovf.res_cnt: got %0d expected 64", res_cnt); end
    checks++; if (res_data !== 16'h4282) begin fails++; $display("[TB] FAIL ovf.res_data: got %h expected 4282", res_data); end
    checks++; if (ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf.held: got %b expected 1", ovf); end
    consume();
    checks++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL ovf.cleared: got %b expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_one_chunk();
    test_two_chunks();
    test_back_to_back();
    test_inf_nan();
    test_reset_mid_run();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bf16_dot_seq.md
Name: bf16_dot_seq

Overview:
Sequencer in front of bf16_mac_tree. It streams 8-pair operand chunks into the tree, one per cycle, and tracks in-flight chunks with a latency-matched valid/last tag pipe. Tree outputs are accumulated into one bf16 dot-product result, which is presented on a valid/ready result port. One dot product is in flight at a time; the next dot product starts only after the current result is consumed.

Parameters:
TREE_LAT, 2, cycles from registered tree inputs to the tree output being valid.
MAX_CHUNKS, 64, maximum chunks per dot product; sets the chunk-counter width.
CNT_W, 7, chunk-counter width, equal to clog2(MAX_CHUNKS)+1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
chk_valid  in  1  an operand chunk is offered.
chk_ready  out  1  the sequencer accepts a chunk this cycle.
chk_data  in  256  16 bf16 values; lane k occupies [16k+15:16k]; pair p is lane 2p times lane 2p+1.
chk_last  in  1  the offered chunk is the final chunk of the dot product.
tree_in  out  256  registered operands to bf16_mac_tree in0..in15 (lane k drives in_k).
tree_out  in  16  bf16_mac_tree.out.
res_valid  out  1  result held.
res_ready  in  1  consumer takes the result.
res_data  out  16  bf16 dot-product result.
res_cnt  out  CNT_W  number of chunks summed into res_data.
ovf  out  1  sticky flag: chunk count exceeded MAX_CHUNKS; cleared on result handshake.

Behaviour:
- Reset values: chk_ready=0, tree_in=0, res_valid=0, res_data=0, res_cnt=0, ovf=0, state=IDLE. The tag pipe, accumulator and counter are also cleared.
- Reset mid-operation flushes all in-flight tags, and the partial accumulation is discarded. chk_ready rises on the first cycle after reset deasserts.
- States:
  - IDLE: chk_ready=1. A chunk accept moves to RUN, or to DRAIN if chk_last=1.
  - RUN: chk_ready=1. An accept with chk_last=1 moves to DRAIN.
  - DRAIN: chk_ready=0. Wait until the last tag retires and the accumulator commits, then move to HOLD.
  - HOLD: res_valid=1. On res_valid&&res_ready, move to IDLE. chk_ready is still 0 in the handshake cycle.
- Accept (chk_valid&&chk_ready) at edge E:
  - tree_in<=chk_data.
  - tag pipe stage 0 gets {v=1, first, last}.
  - count increments.
- Without an accept, tree_in<=0 and a v=0 bubble enters the pipe. Bubbles between chunks are legal and do not affect the result.
- The tag pipe is TREE_LAT deep. A tag exiting at an edge means tree_out is sampled at that edge.
- Accumulate on an exiting v=1 tag:
  - first=1: acc<=tree_out (direct load, so -0 and NaN propagate unchanged).
  - otherwise: acc<=bf16_add(acc, tree_out).
  - If last=1, the result register is written from the same computation.
- Result timing:
  - res_valid rises exactly TREE_LAT+1 cycles after the edge that accepted the last chunk (3 cycles at default).
  - res_data/res_cnt stay stable while res_valid=1 and res_ready=0.
- Counter: count saturates at MAX_CHUNKS. The accept that would exceed it sets ovf=1; its data is still issued and summed.
- bf16_add rules:
  - Round-to-nearest-even; subnormal results flush to signed zero.
  - Overflow gives ±Inf (7F80/FF80).
  - Any NaN input, or +Inf + -Inf, gives 16'h7FC1, the same canonical NaN bf16_mac_tree emits.
  - +0 + -0 gives +0.
- Single-chunk dot product: first=last=1, so res_data equals tree_out directly.

Decomposition:
- Shared package bf16_pkg:
  - constants BF16_PINF=16'h7F80, BF16_NINF=16'hFF80, BF16_QNAN=16'h7FC1, BF16_PZERO=16'h0000;
  - tag struct {v, first, last};
  - state enum {IDLE, RUN, DRAIN, HOLD}.
- One sub-module, bf16_add: a combinational two-operand bf16 adder instantiated once for the accumulator. The bf16_mac_tree instance sits outside this block, connected through tree_in/tree_out.

Test Plan:
- One chunk: pairs (3F80,4000),(4040,4080), rest 0, chk_last=1. Response: res_data=4160, res_cnt=1, and res_valid rises 3 cycles after the accept.
- Two chunks: the above, then a chunk with pair (4000,4000), rest 0, last. Response: res_data=4190 (18.0), res_cnt=2.
- Same two chunks with 3 bubble cycles between them and res_ready held 0 for 5 cycles. Response: result still 4190; res_data stable while held; chk_ready=0 throughout DRAIN/HOLD; chk_ready=1 the cycle after the handshake.
- Chunk 1 pair (7F80,3F80) then chunk 2 pair (FF80,3F80), last. Response: res_data=7FC1. Also run a single chunk with pair (7F80,3F80), last. Response: res_data=7F80.
- Assert reset for one cycle mid-RUN with 2 chunks in flight, then send one chunk with pair (BF80,4000), last. Response: res_data=C000, res_cnt=1, and no stale result appears.
- Send MAX_CHUNKS+1 chunks, each with pair (3F80,3F80). Response: ovf=1, res_cnt=MAX_CHUNKS, and ovf is cleared after the result handshake.
